// File: rtl/accumulator_sequencer.sv
// Sequences one summation burst through an external load/transfer accumulator:
// takes operands over valid/ready, strobes load then transfer per operand, reports the sum.
module accumulator_sequencer #(
   parameter int WIDTH   = 16,
   parameter int COUNT_W = 8
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               start,
   input  logic [COUNT_W-1:0] count,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   output logic               acc_clear_n,
   output logic               acc_load,
   output logic               acc_transfer,
   output logic [WIDTH-1:0]   acc_data,
   input  logic [WIDTH-1:0]   acc_sum,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               overflow
);

   // state | meaning
   // IDLE  | waiting for start
   // CLR   | accumulator cleared for one cycle
   // WAIT  | in_ready high, waiting for an operand
   // LOAD  | accumulator captures acc_data
   // XFER  | accumulator adds captured operand to its sum
   // DONE  | one-cycle done pulse, result captured
   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_WAIT,
      S_LOAD,
      S_XFER,
      S_DONE
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [COUNT_W-1:0] remaining;
   logic               empty_burst;
   logic               carry;

   // a + b carries out of WIDTH bits exactly when a > (2^WIDTH - 1 - b)
   assign carry = (acc_sum > ~acc_data);

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (start) state_nxt = (count == '0) ? S_DONE : S_CLR;
         end
         S_CLR:  state_nxt = S_WAIT;
         S_WAIT: begin
            if (in_valid && in_ready) state_nxt = S_LOAD;
         end
         S_LOAD: state_nxt = S_XFER;
         S_XFER: begin
            if ((remaining == '0) || (remaining == COUNT_W'(1))) state_nxt = S_DONE;
            else state_nxt = S_WAIT;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state        <= S_IDLE;
         acc_clear_n  <= 1'b0;
         acc_load     <= 1'b0;
         acc_transfer <= 1'b0;
         acc_data     <= '0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         overflow     <= 1'b0;
         remaining    <= '0;
         empty_burst  <= 1'b0;
      end else begin
         state        <= state_nxt;
         // outputs are decoded from the next state so they line up with the state register
         acc_clear_n  <= (state_nxt != S_CLR);
         acc_load     <= (state_nxt == S_LOAD);
         acc_transfer <= (state_nxt == S_XFER);
         in_ready     <= (state_nxt == S_WAIT);
         busy         <= (state_nxt != S_IDLE);
         done         <= (state_nxt == S_DONE);

         unique case (state)
            S_IDLE: begin
               if (start) begin
                  remaining   <= count;
                  empty_burst <= (count == '0);
                  overflow    <= 1'b0;
                  result      <= '0;
               end
            end
            S_WAIT: begin
               if (in_valid && in_ready) acc_data <= in_data;
            end
            S_XFER: begin
               if (carry) overflow <= 1'b1;
               if (remaining != '0) remaining <= remaining - COUNT_W'(1);
            end
            S_DONE: begin
               // an empty burst never cleared the accumulator, so its sum is stale
               result <= empty_burst ? '0 : acc_sum;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Bench for accumulator_sequencer: accumulator model, burst-level expected values,
// and one negedge compare process.
module tb_accumulator_sequencer;

   logic        clk;
   logic        clear;
   logic        start;
   logic [7:0]  count;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        acc_clear_n;
   logic        acc_load;
   logic        acc_transfer;
   logic [15:0] acc_data;
   logic [15:0] acc_sum;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        overflow;

   accumulator_sequencer #(.WIDTH(16), .COUNT_W(8)) dut (
      .clock        (clk),
      .clear        (clear),
      .start        (start),
      .count        (count),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .acc_clear_n  (acc_clear_n),
      .acc_load     (acc_load),
      .acc_transfer (acc_transfer),
      .acc_data     (acc_data),
      .acc_sum      (acc_sum),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .overflow     (overflow)
   );

   // external load/transfer accumulator
   logic [15:0] m_acc;
   logic [15:0] m_reg;
   always @(posedge clk or negedge acc_clear_n) begin
      if (!acc_clear_n) begin
         m_acc <= 16'h0;
         m_reg <= 16'h0;
      end else if (acc_load) begin
         m_reg <= acc_data;
      end else if (acc_transfer) begin
         m_acc <= m_acc + m_reg;
      end
   end
   assign acc_sum = m_acc;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc;
   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // burst-level model, written only by the stimulus process
   logic [15:0] ops[$];
   int          m_n;
   int          m_sum;
   bit          m_ovf;
   bit          in_burst;
   int          start_cyc;
   int          exp_done_cyc;
   logic [15:0] exp_result;
   bit          exp_ovf;
   logic [15:0] cur_op;
   bit          stall_flag;
   bit          to_flag;
   bit          lit_pending;
   logic [15:0] lit_res;
   bit          lit_ov;
   int          lit_dly;

   // counters, written only by the compare process
   int n_checks;
   int n_fail;
   int n_load;
   int n_xfer;
   int last_rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      n_load   = 0;
      n_xfer   = 0;
      last_rst = -10;
      forever begin
         @(negedge clk);
         chk("timeout", 32'(to_flag), 32'd0);
         if (!clear) begin
            last_rst = cyc;
            chk("rst_strobes", {29'd0, acc_clear_n, acc_load, acc_transfer}, 32'd0);
            chk("rst_flags", {28'd0, in_ready, busy, done, overflow}, 32'd0);
            chk("rst_result", 32'(result), 32'd0);
            chk("rst_acc_data", 32'(acc_data), 32'd0);
         end else begin
            chk("load_xfer_excl", 32'(acc_load & acc_transfer), 32'd0);
            chk("busy", 32'(busy), 32'(in_burst && cyc > start_cyc && cyc <= exp_done_cyc));
            chk("done", 32'(done), 32'(in_burst && cyc == exp_done_cyc));
            if (stall_flag) chk("ready_in_stall", 32'(in_ready), 32'd1);
            if (in_ready) chk("no_strobe_in_wait", 32'(acc_load | acc_transfer), 32'd0);
            if (lit_pending) begin
               chk("result_lit", 32'(result), 32'(lit_res));
               chk("overflow_lit", 32'(overflow), 32'(lit_ov));
            end
            if (!busy) begin
               n_load = 0;
               n_xfer = 0;
               chk("idle_quiet", {29'd0, in_ready, acc_load, acc_transfer}, 32'd0);
               chk("idle_result", 32'(result), 32'(exp_result));
               chk("idle_overflow", 32'(overflow), 32'(exp_ovf));
               if (cyc >= last_rst + 2) chk("idle_clear_n", 32'(acc_clear_n), 32'd1);
            end else begin
               if (acc_load) begin
                  n_load++;
                  chk("acc_data", 32'(acc_data), 32'(cur_op));
               end
               if (acc_transfer) n_xfer++;
               chk("busy_result", 32'(result), 32'd0);
               chk("clear_n", 32'(acc_clear_n), 32'(!(m_n > 0 && cyc == start_cyc + 1)));
               if (done && in_burst) begin
                  chk("n_load", 32'(n_load), 32'(m_n));
                  chk("n_xfer", 32'(n_xfer), 32'(m_n));
                  chk("done_overflow", 32'(overflow), 32'(m_ovf));
                  chk("done_delay_lit", 32'(cyc - start_cyc), 32'(lit_dly));
               end
            end
         end
      end
   end

   task automatic timeout_hit();
      to_flag  = 1'b1;
      in_burst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      to_flag = 1'b0;
   endtask

   // Runs one burst over ops[0..n-1]; entered and left 1 time unit after a rising edge.
   task automatic run_burst(input int n, input logic [15:0] l_res, input bit l_ov, input int l_dly,
                            input int stall_idx, input int stall_len, input bit poke,
                            input int abort_idx);
      int t;
      m_n   = n;
      m_sum = 0;
      m_ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         m_sum = m_sum + int'(ops[i]);
         if (m_sum > 65535) begin
            m_ovf = 1'b1;
            m_sum = m_sum - 65536;
         end
      end
      start_cyc    = cyc;
      exp_done_cyc = (n == 0) ? cyc + 1
                   : cyc + 2 + 3 * n + ((stall_idx >= 0 && stall_idx < n) ? stall_len : 0);
      lit_dly  = l_dly;
      in_burst = 1'b1;
      start    = 1'b1;
      count    = 8'(n);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < n; k++) begin
         t = 0;
         while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
         end
         if (!in_ready) begin
            timeout_hit();
            return;
         end
         if (k == stall_idx) begin
            stall_flag = 1'b1;
            repeat (stall_len) begin
               @(posedge clk); #1;
            end
            stall_flag = 1'b0;
         end
         cur_op   = ops[k];
         in_data  = ops[k];
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (k == abort_idx) begin
            in_burst   = 1'b0;
            exp_result = 16'h0;
            exp_ovf    = 1'b0;
            clear      = 1'b0;
            @(posedge clk); #1;
            clear = 1'b1;
            return;
         end
         if (poke && k == 0) begin
            start = 1'b1;
            count = 8'd5;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      t = 0;
      while (!done && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      if (!done) begin
         timeout_hit();
         return;
      end
      exp_result = 16'(m_sum);
      exp_ovf    = m_ovf;
      lit_res    = l_res;
      lit_ov     = l_ov;
      @(posedge clk); #1;
      in_burst    = 1'b0;
      lit_pending = 1'b1;
      @(posedge clk); #1;
      lit_pending = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear        = 1'b0;
      start        = 1'b0;
      count        = 8'd0;
      in_valid     = 1'b0;
      in_data      = 16'h0;
      in_burst     = 1'b0;
      start_cyc    = 0;
      exp_done_cyc = 0;
      exp_result   = 16'h0;
      exp_ovf      = 1'b0;
      cur_op       = 16'h0;
      stall_flag   = 1'b0;
      to_flag      = 1'b0;
      lit_pending  = 1'b0;
      lit_res      = 16'h0;
      lit_ov       = 1'b0;
      lit_dly      = 0;
      m_n          = 0;
      m_sum        = 0;
      m_ovf        = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      clear = 1'b1;

      // basic burst, start in the first cycle after reset release
      ops = '{16'h0010, 16'h0020, 16'h0003};
      run_burst(3, 16'h0033, 1'b0, 11, -1, 0, 1'b0, -1);
      // backpressure: four idle WAIT cycles before the second operand
      run_burst(3, 16'h0033, 1'b0, 15, 1, 4, 1'b0, -1);
      // carry out of 16 bits
      ops = '{16'hFFFF, 16'h0002};
      run_burst(2, 16'h0001, 1'b1, 8, -1, 0, 1'b0, -1);
      ops = '{16'h0005};
      run_burst(1, 16'h0005, 1'b0, 5, -1, 0, 1'b0, -1);
      // empty burst right after a non-zero sum
      ops = {};
      run_burst(0, 16'h0000, 1'b0, 1, -1, 0, 1'b0, -1);
      // start with a different count while busy must be ignored
      ops = '{16'h0001, 16'h0002, 16'h0003};
      run_burst(3, 16'h0006, 1'b0, 11, -1, 0, 1'b1, -1);
      // reset during LOAD of the second operand, then a fresh burst
      ops = '{16'h0100, 16'h0200, 16'h0300};
      run_burst(3, 16'h0000, 1'b0, 0, -1, 0, 1'b0, 1);
      ops = '{16'h0007};
      run_burst(1, 16'h0007, 1'b0, 5, -1, 0, 1'b0, -1);
      // longer wrap-around burst
      ops = '{16'h8000, 16'h7FFF, 16'h0002, 16'h1234};
      run_burst(4, 16'h1235, 1'b1, 14, -1, 0, 1'b0, -1);

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
